// File: rtl/seq_send_uart.sv
// seq_send_uart: takes one byte from the sequencer and prints it on the UART as
// two uppercase hex digits followed by CR LF. Each character is sent 8N1 at
// BAUD_DIV clocks per bit, and the four characters of a message follow each
// other with no idle time between them.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | line high, ready for a byte
// START | start bit (0) of the current character
// DATA  | data bit bit_idx of the current character, LSB first
// STOP  | stop bit (1); then the next character, or back to IDLE
module seq_send_uart #(
  parameter int BAUD_DIV = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_vld,
  input  logic [7:0] in_data,
  output logic       in_rdy,
  output logic       tx,
  output logic       busy
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] baud_cnt, baud_nxt;
  logic [2:0]    bit_idx, bit_nxt;
  logic [1:0]    char_idx, char_nxt;
  logic [7:0]    byte_q, byte_nxt;
  logic [7:0]    char_cur;
  logic          tx_nxt, rdy_nxt, busy_nxt;
  logic          bit_end;
  logic          accept;

  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    if (nib < 4'd10) return 8'h30 + {4'h0, nib};
    return 8'h37 + {4'h0, nib};
  endfunction

  assign bit_end = (baud_cnt == BAUD_LAST);

  // The registered in_rdy lags the state by one cycle, so it is still high in
  // the cycle right after an accept; the state test keeps that cycle from
  // taking a second byte.
  assign accept = in_vld && in_rdy && (state == IDLE);

  // Current character chosen from the character index and the latched byte.
  always_comb begin
    char_cur = 8'h0A;
    case (char_idx)
      2'd0:    char_cur = hex_ascii(byte_q[7:4]);
      2'd1:    char_cur = hex_ascii(byte_q[3:0]);
      2'd2:    char_cur = 8'h0D;
      default: char_cur = 8'h0A;
    endcase
  end

  // Next-state, counter and output decode.
  always_comb begin
    state_nxt = state;
    baud_nxt  = baud_cnt;
    bit_nxt   = bit_idx;
    char_nxt  = char_idx;
    byte_nxt  = byte_q;
    tx_nxt    = 1'b1;
    rdy_nxt   = 1'b0;
    busy_nxt  = 1'b1;

    case (state)
      IDLE: begin
        rdy_nxt  = 1'b1;
        busy_nxt = 1'b0;
        if (accept) begin
          state_nxt = START;
          byte_nxt  = in_data;
          baud_nxt  = '0;
          bit_nxt   = '0;
          char_nxt  = '0;
        end
      end
      START: begin
        tx_nxt = 1'b0;
        if (bit_end) begin
          state_nxt = DATA;
          baud_nxt  = '0;
          bit_nxt   = '0;
        end else begin
          baud_nxt = baud_cnt + CW'(1);
        end
      end
      DATA: begin
        tx_nxt = char_cur[bit_idx];
        if (bit_end) begin
          baud_nxt = '0;
          if (bit_idx == 3'd7) begin
            state_nxt = STOP;
            bit_nxt   = '0;
          end else begin
            bit_nxt = bit_idx + 3'd1;
          end
        end else begin
          baud_nxt = baud_cnt + CW'(1);
        end
      end
      STOP: begin
        tx_nxt = 1'b1;
        if (bit_end) begin
          baud_nxt = '0;
          if (char_idx == 2'd3) begin
            state_nxt = IDLE;
            char_nxt  = '0;
          end else begin
            state_nxt = START;
            char_nxt  = char_idx + 2'd1;
          end
        end else begin
          baud_nxt = baud_cnt + CW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, counters, byte latch and registered outputs; reset aborts any message.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      char_idx <= '0;
      byte_q   <= '0;
      tx       <= 1'b1;
      in_rdy   <= 1'b1;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_nxt;
      bit_idx  <= bit_nxt;
      char_idx <= char_nxt;
      byte_q   <= byte_nxt;
      tx       <= tx_nxt;
      in_rdy   <= rdy_nxt;
      busy     <= busy_nxt;
    end
  end

endmodule
